// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard controller.
//   slave  : seen by the controller. D/X/M/F stage status comes in, and
//            stall/flush/bubble controls plus status go out.
//   master : seen by the pipeline datapath, or by a bench standing in for it.
//   clk and rst are not part of the bundle; they stay plain module ports.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       rsD;
    logic             rsUsedD;
    logic [2:0]       rtD;
    logic             rtUsedD;
    logic             regWriteX;
    logic [2:0]       writeRegX;
    logic             regWriteM;
    logic [2:0]       writeRegM;
    logic             branchTakenX;
    logic             haltD;
    logic             instrValidF;

    logic             stallPC;
    logic             f2dEn;
    logic             f2dFlush;
    logic             d2xBubble;
    logic             haltDone;
    logic [CNT_W-1:0] stallCnt;

    modport slave (
        input  rsD, rsUsedD, rtD, rtUsedD, regWriteX, writeRegX,
               regWriteM, writeRegM, branchTakenX, haltD, instrValidF,
        output stallPC, f2dEn, f2dFlush, d2xBubble, haltDone, stallCnt
    );

    modport master (
        output rsD, rsUsedD, rtD, rtUsedD, regWriteX, writeRegX,
               regWriteM, writeRegM, branchTakenX, haltD, instrValidF,
        input  stallPC, f2dEn, f2dFlush, d2xBubble, haltDone, stallCnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the five-stage pipeline.
//   - Stalls D on RAW hazards against X and M. There is no forwarding.
//     WB needs no check because the register file writes before it reads.
//   - Flushes wrong-path work when a branch resolves taken in X.
//   - Feeds NOPs into D while instruction memory is not ready.
//   - Drains the pipe after a HALT, then stays halted until reset.
//   - Counts RAW and imem stall cycles, saturating at all-ones.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : pipe_hazard_ctrl_if.slave (stage status in; stallPC, f2dEn,
//          f2dFlush, d2xBubble, haltDone and stallCnt out)
//
// state  | meaning
// RUN    | normal issue; hazard/branch/halt/imem rules applied combinationally
// DRAIN  | HALT left D; waiting DRAIN_CYCLES for it to retire; front end frozen
// HALTED | fully halted; haltDone set until reset
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           state, state_next;
    logic [DW-1:0]    drain_cnt, drain_next;
    logic [CNT_W-1:0] stall_cnt;
    logic             count_stall;
    logic             haz_x, haz_m, raw;
    logic             stall_pc, f2d_en, f2d_flush, d2x_bubble;

    assign haz_x = bus.regWriteX & ((bus.rsUsedD & (bus.rsD == bus.writeRegX)) |
                                    (bus.rtUsedD & (bus.rtD == bus.writeRegX)));
    assign haz_m = bus.regWriteM & ((bus.rsUsedD & (bus.rsD == bus.writeRegM)) |
                                    (bus.rtUsedD & (bus.rtD == bus.writeRegM)));
    assign raw   = haz_x | haz_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            if (count_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        drain_next  = drain_cnt;
        // The frozen pattern is shared by DRAIN, HALTED and reset.
        stall_pc    = 1'b1;
        f2d_en      = 1'b1;
        f2d_flush   = 1'b1;
        d2x_bubble  = 1'b1;
        count_stall = 1'b0;
        case (state)
            RUN: begin
                if (bus.branchTakenX) begin
                    // Wrong-path D is discarded, so a hazard or HALT seen there is ignored.
                    stall_pc = 1'b0;
                end else if (raw) begin
                    f2d_en      = 1'b0;
                    f2d_flush   = 1'b0;
                    count_stall = 1'b1;
                end else if (bus.haltD) begin
                    d2x_bubble = 1'b0;
                    state_next = DRAIN;
                    drain_next = DW'(DRAIN_CYCLES - 1);
                end else if (!bus.instrValidF) begin
                    d2x_bubble  = 1'b0;
                    count_stall = 1'b1;
                end else begin
                    stall_pc   = 1'b0;
                    f2d_flush  = 1'b0;
                    d2x_bubble = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0)
                    state_next = HALTED;
                else
                    drain_next = drain_cnt - DW'(1);
            end
            HALTED: ;
            default: state_next = RUN;
        endcase
        // While reset is held the state register is already RUN. The outputs
        // are still forced to the frozen pattern so the pipe cannot advance.
        if (rst) begin
            stall_pc    = 1'b1;
            f2d_en      = 1'b1;
            f2d_flush   = 1'b1;
            d2x_bubble  = 1'b1;
            count_stall = 1'b0;
        end
    end

    assign bus.stallPC   = stall_pc;
    assign bus.f2dEn     = f2d_en;
    assign bus.f2dFlush  = f2d_flush;
    assign bus.d2xBubble = d2x_bubble;
    assign bus.haltDone  = (state == HALTED);
    assign bus.stallCnt  = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int CW  = 4;
    localparam int DC  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model, kept at the level of events rather than states.
    // m_halt  : a HALT was accepted since the last reset
    // m_edges : rising edges seen since, and including, the edge that took the HALT
    // m_cnt   : stall cycles, saturating
    bit m_halt;
    int m_edges;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit reads(input logic [2:0] r);
        return (bus.rsUsedD && bus.rsD == r) || (bus.rtUsedD && bus.rtD == r);
    endfunction

    function automatic bit m_raw();
        return (bus.regWriteX && reads(bus.writeRegX)) ||
               (bus.regWriteM && reads(bus.writeRegM));
    endfunction

    // Bit order is {stallPC, f2dEn, f2dFlush, d2xBubble}.
    function automatic logic [3:0] m_ctl();
        if (m_halt)              return 4'b1111;
        if (bus.branchTakenX)    return 4'b0111;
        if (m_raw())             return 4'b1001;
        if (bus.haltD)           return 4'b1110;
        if (!bus.instrValidF)    return 4'b1110;
        return 4'b0100;
    endfunction

    function automatic bit m_counts();
        return !m_halt && !bus.branchTakenX &&
               (m_raw() || (!bus.haltD && !bus.instrValidF));
    endfunction

    task automatic idle();
        bus.rsD = 3'd0; bus.rsUsedD = 1'b0; bus.rtD = 3'd0; bus.rtUsedD = 1'b0;
        bus.regWriteX = 1'b0; bus.writeRegX = 3'd0;
        bus.regWriteM = 1'b0; bus.writeRegM = 3'd0;
        bus.branchTakenX = 1'b0; bus.haltD = 1'b0; bus.instrValidF = 1'b1;
    endtask

    // Called just after a negedge, once the inputs for this cycle are driven.
    // It checks the outputs, advances the model at the edge, and returns at the next negedge.
    task automatic step(input string tag);
        bit cnt_now;
        #1;
        chk({tag, ".ctl"},  {bus.stallPC, bus.f2dEn, bus.f2dFlush, bus.d2xBubble}, m_ctl());
        chk({tag, ".done"}, bus.haltDone, (m_halt && m_edges >= DC + 1));
        chk({tag, ".cnt"},  bus.stallCnt, m_cnt);
        cnt_now = m_counts();
        @(posedge clk);
        if (m_halt) begin
            if (m_edges < 1000) m_edges++;
        end else if (!bus.branchTakenX && !m_raw() && bus.haltD) begin
            m_halt  = 1'b1;
            m_edges = 1;
        end else if (cnt_now) begin
            m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst.ctl",  {bus.stallPC, bus.f2dEn, bus.f2dFlush, bus.d2xBubble}, 4'b1111);
        chk("rst.done", bus.haltDone, 1'b0);
        chk("rst.cnt",  bus.stallCnt, 0);
        m_halt = 1'b0; m_edges = 0; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_halt = 1'b0; m_edges = 0; m_cnt = 0;
        @(negedge clk);
        do_reset();

        step("idle");

        // Producer in X, then in M, then retired.
        bus.rsD = 3'd3; bus.rsUsedD = 1'b1;
        bus.regWriteX = 1'b1; bus.writeRegX = 3'd3;
        step("rawx0");
        bus.regWriteX = 1'b0; bus.regWriteM = 1'b1; bus.writeRegM = 3'd3;
        step("rawx1");
        bus.regWriteM = 1'b0;
        step("rawx2");
        chk("rawx.cnt", bus.stallCnt, 2);

        // A taken branch together with RAW flushes and does not count.
        bus.regWriteX = 1'b1; bus.writeRegX = 3'd3; bus.branchTakenX = 1'b1;
        #1 chk("br.ctl", {bus.stallPC, bus.f2dEn, bus.f2dFlush, bus.d2xBubble}, 4'b0111);
        step("br");
        idle();
        step("br_after");
        chk("br.cnt", bus.stallCnt, 2);

        // RAW together with imem not ready counts once.
        bus.rtD = 3'd5; bus.rtUsedD = 1'b1; bus.regWriteM = 1'b1; bus.writeRegM = 3'd5;
        bus.instrValidF = 1'b0;
        step("rawimem");
        idle();
        chk("rawimem.cnt", bus.stallCnt, 3);

        do_reset();
        bus.instrValidF = 1'b0;
        for (int i = 0; i < 4; i++) step("imem");
        idle();
        step("imem_after");
        chk("imem.cnt", bus.stallCnt, 4);

        // HALT drains for DC cycles, then sticks while the inputs toggle.
        bus.haltD = 1'b1;
        step("halt");
        for (int i = 0; i < 8; i++) begin
            bus.haltD = 1'($urandom); bus.branchTakenX = 1'($urandom);
            bus.instrValidF = 1'($urandom); bus.regWriteX = 1'($urandom);
            bus.rsUsedD = 1'($urandom); bus.rsD = 3'($urandom); bus.writeRegX = 3'($urandom);
            step("drain");
            if (i == DC - 1) chk("halt.done_edge4", bus.haltDone, 1'b1);
            if (i == DC - 2) chk("halt.done_edge3", bus.haltDone, 1'b0);
        end
        idle();
        do_reset();
        chk("halt.cleared", bus.haltDone, 1'b0);

        // Saturation at the counter width.
        bus.instrValidF = 1'b0;
        for (int i = 0; i < 20; i++) step("sat");
        idle();
        chk("sat.cnt", bus.stallCnt, SAT);

        // Reset in the middle of DRAIN.
        do_reset();
        bus.haltD = 1'b1;
        step("mid_halt");
        idle();
        step("mid_drain");
        do_reset();
        step("mid_after");
        chk("mid.done", bus.haltDone, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            bus.rsD = 3'($urandom_range(0, 3)); bus.rsUsedD = 1'($urandom);
            bus.rtD = 3'($urandom_range(0, 3)); bus.rtUsedD = 1'($urandom);
            bus.regWriteX = 1'($urandom); bus.writeRegX = 3'($urandom_range(0, 3));
            bus.regWriteM = 1'($urandom); bus.writeRegM = 3'($urandom_range(0, 3));
            bus.branchTakenX = ($urandom_range(0, 7) == 0);
            bus.haltD        = ($urandom_range(0, 24) == 0);
            bus.instrValidF  = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage WISC-F24 core. It drives the PC hold, the fetch-to-decode register enable and flush, and the decode-to-execute bubble. It detects RAW hazards against the X and M stages (no forwarding), flushes wrong-path instructions on a taken branch resolved in X, and inserts NOPs while instruction memory is not ready. It also sequences an orderly HALT drain, and keeps a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles to spend in DRAIN after HALT leaves D (X→M→WB).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rsD  in  3  rs register index of instruction in D
- rsUsedD  in  1  instruction in D reads rs
- rtD  in  3  rt register index of instruction in D
- rtUsedD  in  1  instruction in D reads rt
- regWriteX  in  1  instruction in X writes the register file
- writeRegX  in  3  destination index of instruction in X
- regWriteM  in  1  instruction in M writes the register file
- writeRegM  in  3  destination index of instruction in M
- branchTakenX  in  1  branch/jump in X redirects PC this cycle
- haltD  in  1  instruction in D is HALT
- instrValidF  in  1  instruction memory output valid this cycle
- stallPC  out  1  PC holds its value
- f2dEn  out  1  F2D register write enable
- f2dFlush  out  1  F2D loads NOP (wins over f2dEn hold)
- d2xBubble  out  1  D2X loads NOP
- haltDone  out  1  sticky: processor fully halted
- stallCnt  out  CNT_W  stall cycles counted

## Operation
- State machine: RUN, DRAIN, HALTED. State register and counters use async rst.
- RAW hazard: hazX = regWriteX & ((rsUsedD & rsD==writeRegX) | (rtUsedD & rtD==writeRegX)). hazM is the same check against the M signals. raw = hazX | hazM. The WB stage needs no check because the register file writes before it reads.
- RUN outputs are combinational. Priority is highest first:
  1. branchTakenX: f2dFlush=1, d2xBubble=1, stallPC=0, f2dEn=1. Any hazard or HALT in D is discarded as wrong-path.
  2. raw: stallPC=1, f2dEn=0, f2dFlush=0, d2xBubble=1. D is held and one bubble enters X per cycle.
  3. haltD: HALT advances to X (d2xBubble=0), stallPC=1, f2dFlush=1. Next state is DRAIN, and drainCnt loads DRAIN_CYCLES-1.
  4. !instrValidF: stallPC=1, f2dEn=1, f2dFlush=1. D receives a NOP.
  5. Otherwise: stallPC=0, f2dEn=1, f2dFlush=0, d2xBubble=0.
- DRAIN:
  - Outputs: stallPC=1, f2dEn=1, f2dFlush=1, d2xBubble=1.
  - All inputs are ignored; older instructions are already past X.
  - drainCnt decrements each cycle. When drainCnt==0, next state is HALTED.
- HALTED: outputs are the same as DRAIN, and haltDone=1. The block stays in HALTED until rst.
- stallCnt:
  - Increments on every RUN cycle where stallPC=1 due to rule 2 or rule 4.
  - Saturates at all-ones and never wraps.
  - Does not count in DRAIN or HALTED.

## Timing
- Reset: while rst is high, and after it falls, the block holds these values:
  - state=RUN, drainCnt=0, stallCnt=0, haltDone=0.
  - stallPC=1, f2dEn=1, f2dFlush=1, d2xBubble=1 while rst is high.
- Reset asserted mid-DRAIN or in HALTED returns the block to RUN immediately (async). Outputs are forced to the reset values in the same cycle.
- Control latency is zero cycles: stall, flush and bubble respond in the same cycle as the input condition.
- State changes and stallCnt take effect at the next rising edge.
- RAW with X then M: a dependent instruction stalls 2 cycles if its producer is in X, and 1 cycle if the producer is in M.
- DRAIN lasts exactly DRAIN_CYCLES cycles. haltDone rises DRAIN_CYCLES+1 edges after the edge that captured haltD in RUN.
- Simultaneous branchTakenX and raw: flush only. stallCnt does not increment.
- Simultaneous raw and !instrValidF: the RAW rule applies and stallCnt increments once.

## Test plan
- Reset: assert rst mid-cycle, then release → stallCnt=0, haltDone=0, state=RUN. With no hazards and instrValidF=1, the outputs are stallPC=0, f2dEn=1, f2dFlush=0, d2xBubble=0.
- RAW from X: regWriteX=1, writeRegX=3, rsD=3, rsUsedD=1, with the X→M advance modeled → two cycles of stallPC=1, f2dEn=0, d2xBubble=1, then release. stallCnt=2.
- Branch vs RAW: branchTakenX=1 together with a RAW match → f2dFlush=1, d2xBubble=1, stallPC=0, and stallCnt unchanged.
- Imem wait: instrValidF=0 for 4 cycles → stallPC=1, f2dFlush=1 each cycle, and stallCnt=4.
- HALT drain: haltD=1 in RUN → stallPC=1 from then on. haltDone=1 after 4 edges (DRAIN_CYCLES=3), and stays set while the inputs toggle. rst clears it.
- Saturation and mid-drain reset: with CNT_W=4, stall for 20 cycles → stallCnt=15. Asserting rst during DRAIN → RUN, haltDone=0.
